// File: rtl/dec_requant.sv
// rtl/dec_requant.sv - decimate-by-DEC, round/shift/saturate requantiser with 4-entry output FIFO
// One phase of every DEC input samples is kept, requantised in one stage, then queued for the consumer.
module dec_requant #(
   parameter int word_size_in  = 20,
   parameter int word_size_out = 12,
   parameter int DEC           = 8,
   parameter int SHIFT         = 8,
   parameter int PHASE         = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [word_size_in-1:0]  X,
   input  logic                     x_en,
   input  logic                     phase_rst,
   output logic [word_size_out-1:0] Y,
   output logic                     y_valid,
   input  logic                     y_ready,
   output logic                     sat_flag,
   output logic [7:0]               drop_cnt
);

   localparam int PH_W = $clog2(DEC);
   localparam int WS   = word_size_in + 1;
   localparam logic [WS-1:0]        C_RND = {{(WS-1){1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [WS-1:0] C_MAX = WS'((2 ** (word_size_out - 1)) - 1);
   localparam logic signed [WS-1:0] C_MIN = -C_MAX - WS'(1);

   logic [PH_W-1:0]          r_ph;
   logic                     r_s1_valid;
   logic [word_size_out-1:0] r_s1_data;
   logic [word_size_out-1:0] r_mem [4];
   logic [1:0]               r_wr_ptr;
   logic [1:0]               r_rd_ptr;
   logic [2:0]               r_count;
   logic                     r_sat;
   logic [7:0]               r_drop;

   logic [PH_W-1:0]          w_eff_ph;
   logic [PH_W-1:0]          w_ph_nxt;
   logic                     w_keep;
   logic [WS-1:0]            w_sum;
   logic signed [WS-1:0]     w_sum_s;
   logic signed [WS-1:0]     w_shr;
   logic                     w_clip;
   logic [word_size_out-1:0] w_clamped;
   logic                     w_full;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_drop;

   // A sample arriving together with phase_rst is phase 0 whatever the counter held.
   always_comb begin
      w_eff_ph = phase_rst ? '0 : r_ph;
      w_keep   = x_en && (w_eff_ph == PH_W'(PHASE));
      w_ph_nxt = r_ph;
      if (phase_rst && x_en) begin
         w_ph_nxt = PH_W'(1);
      end else if (phase_rst) begin
         w_ph_nxt = '0;
      end else if (x_en) begin
         w_ph_nxt = (r_ph == PH_W'(DEC - 1)) ? '0 : r_ph + PH_W'(1);
      end
   end

   // One guard bit keeps the rounding add from overflowing before the arithmetic shift.
   always_comb begin
      w_sum     = {X[word_size_in-1], X} + C_RND;
      w_sum_s   = w_sum;
      w_shr     = w_sum_s >>> SHIFT;
      w_clip    = 1'b0;
      w_clamped = w_shr[word_size_out-1:0];
      if (w_shr > C_MAX) begin
         w_clip    = 1'b1;
         w_clamped = C_MAX[word_size_out-1:0];
      end else if (w_shr < C_MIN) begin
         w_clip    = 1'b1;
         w_clamped = C_MIN[word_size_out-1:0];
      end
   end

   always_comb begin
      w_full  = r_count[2];
      y_valid = (r_count != 3'd0);
      w_pop   = y_valid && y_ready;
      w_push  = r_s1_valid && (!w_full || w_pop);
      w_drop  = r_s1_valid && w_full && !w_pop;
      Y       = y_valid ? r_mem[r_rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ph       <= '0;
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_count    <= 3'd0;
         r_sat      <= 1'b0;
         r_drop     <= 8'd0;
      end else begin
         r_ph       <= w_ph_nxt;
         r_s1_valid <= w_keep;
         r_s1_data  <= w_clamped;
         if (w_keep && w_clip) begin
            r_sat <= 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // When full, a push with a pop lands in the slot being vacated, so order is kept.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_s1_data;
      end
   end

   assign sat_flag = r_sat;
   assign drop_cnt = r_drop;

endmodule

// File: tb/tb_dec_requant.sv
// tb/tb_dec_requant.sv - directed self-checking bench for dec_requant
// Vector table for rounding/saturation plus sequences for decimation, overflow, realignment and reset.
module tb_dec_requant;

   logic        clk;
   logic        reset;
   logic [19:0] X;
   logic        x_en;
   logic        phase_rst;
   logic [11:0] Y;
   logic        y_valid;
   logic        y_ready;
   logic        sat_flag;
   logic [7:0]  drop_cnt;

   int n_checks;
   int n_err;

   dec_requant dut (
      .clk       (clk),
      .reset     (reset),
      .X         (X),
      .x_en      (x_en),
      .phase_rst (phase_rst),
      .Y         (Y),
      .y_valid   (y_valid),
      .y_ready   (y_ready),
      .sat_flag  (sat_flag),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int sat;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      x_en = 1'b0;
      phase_rst = 1'b0;
      y_ready = 1'b0;
      X = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   int got [$];
   int cyc [$];

   initial begin
      n_checks = 0;
      n_err = 0;
      vecs[0] = '{x: 384,     y: 2,     sat: 0};
      vecs[1] = '{x: -384,    y: -1,    sat: 0};
      vecs[2] = '{x: 127,     y: 0,     sat: 0};
      vecs[3] = '{x: 128,     y: 1,     sat: 0};
      vecs[4] = '{x: -129,    y: -1,    sat: 0};
      vecs[5] = '{x: 524287,  y: 2047,  sat: 1};
      vecs[6] = '{x: -524288, y: -2048, sat: 1};
      vecs[7] = '{x: 0,       y: 0,     sat: 1};

      do_reset();
      chk("reset_y_valid", int'(y_valid), 0);
      chk("reset_Y", int'($signed(Y)), 0);
      chk("reset_sat", int'(sat_flag), 0);
      chk("reset_drop", int'(drop_cnt), 0);

      // Each vector is forced to phase 0 with phase_rst&x_en, then read two cycles later.
      for (int i = 0; i < 8; i++) begin
         x_en = 1'b1;
         phase_rst = 1'b1;
         X = 20'(vecs[i].x);
         tick();
         x_en = 1'b0;
         phase_rst = 1'b0;
         X = '0;
         tick();
         chk($sformatf("vec%0d_valid", i), int'(y_valid), 1);
         chk($sformatf("vec%0d_Y", i), int'($signed(Y)), vecs[i].y);
         chk($sformatf("vec%0d_sat", i), int'(sat_flag), vecs[i].sat);
         y_ready = 1'b1;
         tick();
         y_ready = 1'b0;
         chk($sformatf("vec%0d_popped", i), int'(y_valid), 0);
      end

      // Free-running decimation: one output per 8 inputs, first at cycle 2.
      do_reset();
      chk("sat_cleared_by_reset", int'(sat_flag), 0);
      y_ready = 1'b1;
      got.delete();
      cyc.delete();
      for (int i = 0; i < 30; i++) begin
         x_en = (i < 24);
         X = (i == 0) ? 20'd384 : 20'd0;
         tick();
         if (y_valid) begin
            got.push_back(int'($signed(Y)));
            cyc.push_back(i + 1);
         end
      end
      x_en = 1'b0;
      chk("dec_out_count", got.size(), 3);
      chk("dec_first_cycle", (cyc.size() > 0) ? cyc[0] : -1, 2);
      chk("dec_first_Y", (got.size() > 0) ? got[0] : -999, 2);
      chk("dec_second_cycle", (cyc.size() > 1) ? cyc[1] : -1, 10);
      chk("dec_third_cycle", (cyc.size() > 2) ? cyc[2] : -1, 18);

      // Overflow: six kept samples (values 1..6) with the consumer stalled.
      do_reset();
      for (int i = 0; i < 48; i++) begin
         x_en = 1'b1;
         X = ((i % 8) == 0) ? 20'(((i / 8) + 1) * 256) : 20'd0;
         tick();
      end
      x_en = 1'b0;
      X = '0;
      tick();
      chk("ovf_drop_cnt", int'(drop_cnt), 2);
      chk("ovf_valid", int'(y_valid), 1);
      chk("ovf_head", int'($signed(Y)), 1);
      // Seventh sample reaches the full FIFO in the same cycle as a pop.
      x_en = 1'b1;
      X = 20'(7 * 256);
      tick();
      x_en = 1'b0;
      X = '0;
      y_ready = 1'b1;
      chk("full_pushpop_head", int'($signed(Y)), 1);
      tick();
      y_ready = 1'b0;
      chk("full_pushpop_nodrop", int'(drop_cnt), 2);
      chk("full_pushpop_newhead", int'($signed(Y)), 2);
      got.delete();
      for (int j = 0; j < 8; j++) begin
         if (y_valid) got.push_back(int'($signed(Y)));
         y_ready = 1'b1;
         tick();
      end
      y_ready = 1'b0;
      chk("drain_count", got.size(), 4);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("drain_%0d", j), (j < got.size()) ? got[j] : -999, (j < 3) ? j + 2 : 7);
      end

      // Reset mid-operation with three entries held and drop_cnt non-zero.
      for (int k = 0; k < 3; k++) begin
         x_en = 1'b1;
         phase_rst = 1'b1;
         X = 20'((5 + k) * 256);
         tick();
      end
      x_en = 1'b0;
      phase_rst = 1'b0;
      tick();
      chk("pre_reset_valid", int'(y_valid), 1);
      chk("pre_reset_head", int'($signed(Y)), 5);
      reset = 1'b0;
      x_en = 1'b1;
      X = 20'(100 * 256);
      tick();
      reset = 1'b1;
      x_en = 1'b0;
      X = '0;
      chk("midrst_valid", int'(y_valid), 0);
      chk("midrst_drop", int'(drop_cnt), 0);
      tick();
      tick();
      chk("midrst_no_capture", int'(y_valid), 0);
      x_en = 1'b1;
      X = 20'(9 * 256);
      tick();
      x_en = 1'b0;
      X = '0;
      tick();
      chk("midrst_first_kept_valid", int'(y_valid), 1);
      chk("midrst_first_kept_Y", int'($signed(Y)), 9);

      // Realignment at input index 3.
      do_reset();
      y_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 26; i++) begin
         x_en = (i < 24);
         phase_rst = (i == 3);
         X = (i < 24) ? 20'(i * 256) : 20'd0;
         tick();
         if (y_valid) got.push_back(int'($signed(Y)));
      end
      x_en = 1'b0;
      phase_rst = 1'b0;
      chk("realign_count", got.size(), 4);
      chk("realign_0", (got.size() > 0) ? got[0] : -999, 0);
      chk("realign_1", (got.size() > 1) ? got[1] : -999, 3);
      chk("realign_2", (got.size() > 2) ? got[2] : -999, 11);
      chk("realign_3", (got.size() > 3) ? got[3] : -999, 19);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/dec_requant.md
DEC_REQUANT -- requirements
Module: dec_requant

Interface
REQ-001 SHALL have parameter word_size_in, default 20, meaning bit-size of the signed FIR output sample X.
REQ-002 SHALL have parameter word_size_out, default 12, meaning bit-size of the signed requantised output Y.
REQ-003 SHALL have parameter DEC, default 8, meaning the decimation factor, legal range 2..16.
REQ-004 SHALL have parameter SHIFT, default 8, meaning the right-shift applied before saturation, legal range 1..word_size_in-2.
REQ-005 SHALL have parameter PHASE, default 0, meaning the kept phase, legal range 0..DEC-1.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit, the reset; reset is synchronous and active-low.
REQ-008 SHALL have port X, input, word_size_in bits, the signed FIR output sample.
REQ-009 SHALL have port x_en, input, 1 bit, which qualifies X as a new sample.
REQ-010 SHALL have port phase_rst, input, 1 bit, which realigns the phase counter.
REQ-011 SHALL have port Y, output, word_size_out bits, the signed decimated sample at the FIFO head.
REQ-012 SHALL have port y_valid, output, 1 bit, meaning the FIFO is not empty.
REQ-013 SHALL have port y_ready, input, 1 bit, the consumer accept signal.
REQ-014 SHALL have port sat_flag, output, 1 bit, a sticky flag meaning saturation occurred.
REQ-015 SHALL have port drop_cnt, output, 8 bits, the saturating count of dropped samples.

Function
REQ-016 SHALL keep a phase counter ph in the range 0..DEC-1 that increments on each x_en and wraps from DEC-1 to 0.
REQ-017 SHALL force ph to 1 on phase_rst&x_en, and to 0 on phase_rst alone; the sample presented with phase_rst&x_en is treated as phase 0.
REQ-018 SHALL capture X at cycle T when x_en is high and the effective phase equals PHASE; all other samples are discarded.
REQ-019 SHALL compute r = (X + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half toward +inf) at full width with no intermediate overflow.
REQ-020 SHALL clamp r to the range [-2^(word_size_out-1), 2^(word_size_out-1)-1], and set sat_flag when clamping occurs.
REQ-021 SHALL register the result in a single pipeline stage (s1) at T+1 and write it into a 4-entry FIFO at the edge that ends cycle T+1, so that the earliest y_valid is at T+2.
REQ-022 SHALL present Y as the FIFO head; Y SHALL remain stable while y_valid&!y_ready.
REQ-023 SHALL pop the FIFO on the y_valid&y_ready handshake; y_ready while empty SHALL have no effect.
REQ-024 SHALL accept a push into a full FIFO when a pop occurs in the same cycle; the occupancy stays at 4 and ordering is preserved.
REQ-025 SHALL discard the s1 sample on a push into a full FIFO without a pop, increment drop_cnt, leave the FIFO contents unchanged, and hold drop_cnt at 255 once reached.
REQ-026 SHALL perform a simultaneous push and pop on an empty FIFO as a push only; there is no bypass.
REQ-027 SHALL advance ph on every x_en regardless of FIFO state, so that backpressure never stalls the phase.
REQ-028 SHALL keep FIFO read and write pointers 2 bits wide plus a 3-bit count, wrapping modulo 4.

Reset
REQ-029 SHALL, while reset is low at a clk edge, clear ph, s1 valid, FIFO pointers and count, sat_flag and drop_cnt to 0, and drive Y to 0 and y_valid to 0.
REQ-030 SHALL lose any sample in s1 or the FIFO when reset is asserted mid-operation, and SHALL capture nothing during the reset cycle.
REQ-031 SHALL treat the first x_en after reset release as phase 0.

Verification (defaults DEC=8, SHIFT=8, word_size_out=12, PHASE=0)
REQ-032 SHALL verify: x_en constant 1 with X=384 on sample 0 and X=0 otherwise, y_ready=1 -> Y=2 with y_valid for one cycle at T+2, and exactly one output per 8 inputs.
REQ-033 SHALL verify rounding: X=-384 -> Y=-1; X=127 -> Y=0; X=128 -> Y=1; X=-129 -> Y=-1.
REQ-034 SHALL verify saturation: X=524287 -> Y=2047 with sat_flag=1; X=-524288 -> Y=-2048; sat_flag stays 1 until reset.
REQ-035 SHALL verify overflow: y_ready=0 for 6 kept samples -> 4 stored and drop_cnt=2; y_ready=1 thereafter -> the first 4 samples are read in order.
REQ-036 SHALL verify realignment: phase_rst&x_en at input index 3 -> the following kept samples are input indices 3, 11, 19.
REQ-037 SHALL verify reset mid-operation: reset low for 1 cycle with 3 FIFO entries held -> y_valid=0, drop_cnt=0, and the first kept sample after release is the first x_en.
